// File: rtl/vip_cti_frame_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vip_cti_frame_sequencer: gates CVI video into the sample counter, tracks
// x/y position and latches per-frame active size with change detection. Rev 1.0
// ---------------------------------------------------------------------------
module vip_cti_frame_sequencer #(
    parameter int NUMBER_OF_COLOUR_PLANES      = 3,
    parameter int COLOUR_PLANES_ARE_IN_PARALLEL = 0,
    parameter int LOG2_NUMBER_OF_COLOUR_PLANES = 2,
    parameter int COUNTER_WIDTH                = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable_i,
    input  logic                     vid_valid_i,
    input  logic                     vid_de_i,
    input  logic                     vid_v_sync_i,
    input  logic                     count_sample_i,
    output logic                     count_cycle_o,
    output logic                     sample_sclr_o,
    output logic [COUNTER_WIDTH-1:0] sample_x_o,
    output logic [COUNTER_WIDTH-1:0] line_y_o,
    output logic [COUNTER_WIDTH-1:0] frame_width_o,
    output logic [COUNTER_WIDTH-1:0] frame_height_o,
    output logic                     stats_valid_o,
    output logic                     res_change_o,
    input  logic                     res_change_clr_i,
    output logic [1:0]               state_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SYNC_WAIT = 2'd1,
        ST_FRAME     = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    de_prev_q;
    logic                    vs_prev_q;
    logic                    abort_q;
    logic                    prev_valid_q;
    logic                    stats_valid_q;
    logic                    res_change_q;
    logic [COUNTER_WIDTH-1:0] sample_x_q;
    logic [COUNTER_WIDTH-1:0] line_y_q;
    logic [COUNTER_WIDTH-1:0] last_width_q;
    logic [COUNTER_WIDTH-1:0] frame_width_q;
    logic [COUNTER_WIDTH-1:0] frame_height_q;

    logic                    sample_x_inc_d;
    logic [COUNTER_WIDTH-1:0] sample_x_sat_d;
    logic [COUNTER_WIDTH-1:0] line_y_sat_d;
    logic                    de_fall_d;
    logic                    vs_rise_d;
    logic                    size_differs_d;

    // Plane counting lives in the external sample counter; the plane
    // parameters only describe the configuration it was built for.
    logic unused_cfg;
    assign unused_cfg = (NUMBER_OF_COLOUR_PLANES + COLOUR_PLANES_ARE_IN_PARALLEL
                         + LOG2_NUMBER_OF_COLOUR_PLANES) != 0;

    assign de_fall_d      = vid_valid_i & ~vid_de_i & de_prev_q;
    assign vs_rise_d      = vid_valid_i & vid_v_sync_i & ~vs_prev_q;
    assign sample_x_inc_d = (sample_x_q != '1);
    assign sample_x_sat_d = sample_x_inc_d ? sample_x_q + 1'b1 : sample_x_q;
    assign line_y_sat_d   = (line_y_q != '1) ? line_y_q + 1'b1 : line_y_q;
    assign size_differs_d = (last_width_q != frame_width_q) | (line_y_q != frame_height_q);

    assign count_cycle_o  = vid_valid_i & vid_de_i & (state_q == ST_FRAME) & ~abort_q;
    assign sample_sclr_o  = count_cycle_o & ~de_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            de_prev_q      <= 1'b0;
            vs_prev_q      <= 1'b0;
            abort_q        <= 1'b0;
            prev_valid_q   <= 1'b0;
            stats_valid_q  <= 1'b0;
            res_change_q   <= 1'b0;
            sample_x_q     <= '0;
            line_y_q       <= '0;
            last_width_q   <= '0;
            frame_width_q  <= '0;
            frame_height_q <= '0;
        end else begin
            stats_valid_q <= 1'b0;
            // A set later in this block overrides a same-cycle clear.
            if (res_change_clr_i) begin
                res_change_q <= 1'b0;
            end
            if (vid_valid_i) begin
                de_prev_q <= vid_de_i;
                vs_prev_q <= vid_v_sync_i;
                case (state_q)
                    ST_IDLE: begin
                        if (enable_i) begin
                            state_q <= ST_SYNC_WAIT;
                        end
                    end
                    ST_SYNC_WAIT: begin
                        if (vs_rise_d) begin
                            state_q    <= ST_FRAME;
                            sample_x_q <= '0;
                            line_y_q   <= '0;
                            abort_q    <= 1'b0;
                        end else if (!enable_i) begin
                            state_q      <= ST_IDLE;
                            prev_valid_q <= 1'b0;
                        end
                    end
                    ST_FRAME: begin
                        if (de_fall_d) begin
                            if (abort_q) begin
                                abort_q <= 1'b0;
                            end else begin
                                last_width_q <= sample_x_q;
                                line_y_q     <= line_y_sat_d;
                            end
                        end
                        // Line start wins over frame-end clear: a new line
                        // beginning on the sync edge is line 0 of the next frame.
                        if (sample_sclr_o) begin
                            sample_x_q <= {{(COUNTER_WIDTH-1){1'b0}}, count_sample_i};
                        end else if (vs_rise_d) begin
                            sample_x_q <= '0;
                        end else if (count_sample_i) begin
                            sample_x_q <= sample_x_sat_d;
                        end
                        if (vs_rise_d) begin
                            frame_width_q  <= last_width_q;
                            frame_height_q <= line_y_q;
                            stats_valid_q  <= 1'b1;
                            prev_valid_q   <= 1'b1;
                            line_y_q       <= '0;
                            if (prev_valid_q && size_differs_d) begin
                                res_change_q <= 1'b1;
                            end
                            if (vid_de_i && de_prev_q) begin
                                abort_q <= 1'b1;
                            end
                            if (!enable_i) begin
                                state_q      <= ST_IDLE;
                                prev_valid_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sample_x_o     = sample_x_q;
    assign line_y_o       = line_y_q;
    assign frame_width_o  = frame_width_q;
    assign frame_height_o = frame_height_q;
    assign stats_valid_o  = stats_valid_q;
    assign res_change_o   = res_change_q;
    assign state_o        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_vip_cti_frame_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vip_cti_frame_sequencer: frame-level stimulus against arithmetic size model.
// ---------------------------------------------------------------------------
module tb_vip_cti_frame_sequencer;

    localparam int NP = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable;
    logic          vid_valid;
    logic          vid_de;
    logic          vid_v_sync;
    logic          count_sample;
    logic          res_change_clr;
    logic          count_cycle;
    logic          sample_sclr;
    logic [CW-1:0] sample_x;
    logic [CW-1:0] line_y;
    logic [CW-1:0] frame_width;
    logic [CW-1:0] frame_height;
    logic          stats_valid;
    logic          res_change;
    logic [1:0]    state;

    vip_cti_frame_sequencer #(
        .NUMBER_OF_COLOUR_PLANES      (NP),
        .COLOUR_PLANES_ARE_IN_PARALLEL(0),
        .LOG2_NUMBER_OF_COLOUR_PLANES (2),
        .COUNTER_WIDTH                (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (enable),
        .vid_valid_i     (vid_valid),
        .vid_de_i        (vid_de),
        .vid_v_sync_i    (vid_v_sync),
        .count_sample_i  (count_sample),
        .count_cycle_o   (count_cycle),
        .sample_sclr_o   (sample_sclr),
        .sample_x_o      (sample_x),
        .line_y_o        (line_y),
        .frame_width_o   (frame_width),
        .frame_height_o  (frame_height),
        .stats_valid_o   (stats_valid),
        .res_change_o    (res_change),
        .res_change_clr_i(res_change_clr),
        .state_o         (state)
    );

    always #5 clk = ~clk;

    // Stand-in for the external colour-plane sample counter.
    logic [1:0] plane_q;
    assign count_sample = count_cycle && (sample_sclr ? (NP == 1) : (plane_q == 2'(NP - 1)));
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) plane_q <= 2'd0;
        else if (count_cycle) plane_q <= count_sample ? 2'd0 : (sample_sclr ? 2'd1 : plane_q + 2'd1);
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame size follows from line lengths by plain arithmetic.
    bit m_prev_valid;
    int m_pw, m_ph;
    bit m_rc;
    int m_last_w;
    int m_lines;
    int gap_mode;
    logic cc_s, sc_s;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic d, input logic s);
        vid_valid  = v;
        vid_de     = d;
        vid_v_sync = s;
        #2;
        cc_s = count_cycle;
        sc_s = sample_sclr;
        @(posedge clk);
        #1;
    endtask

    task automatic insert_gap();
        if (gap_mode == 2 || (gap_mode == 1 && $urandom_range(0, 99) < 30))
            step(1'b0, 1'($urandom % 2), 1'($urandom % 2));
    endtask

    task automatic vstep(input logic d, input logic s);
        insert_gap();
        step(1'b1, d, s);
    endtask

    task automatic send_line(input int len, input int hblank);
        for (int i = 0; i < len; i++) begin
            vstep(1'b1, 1'b0);
            check_eq("count_cycle", 32'(cc_s), 32'd1);
            check_eq("sample_sclr", 32'(sc_s), 32'(i == 0));
        end
        check_eq("sample_x_eol", 32'(sample_x), 32'(len / NP));
        vstep(1'b0, 1'b0);
        m_lines++;
        m_last_w = len / NP;
        check_eq("line_y", 32'(line_y), 32'(m_lines));
        for (int i = 1; i < hblank; i++) vstep(1'b0, 1'b0);
    endtask

    task automatic pulse_clr();
        res_change_clr = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        res_change_clr = 1'b0;
        m_rc = 1'b0;
        check_eq("res_change_clr", 32'(res_change), 32'd0);
    endtask

    task automatic frame_end(input bit clr_same, input logic d);
        insert_gap();
        res_change_clr = clr_same;
        step(1'b1, d, 1'b1);
        res_change_clr = 1'b0;
        if (clr_same) m_rc = 1'b0;
        if (m_prev_valid && (m_last_w != m_pw || m_lines != m_ph)) m_rc = 1'b1;
        m_pw = m_last_w;
        m_ph = m_lines;
        m_prev_valid = enable;
        check_eq("stats_valid", 32'(stats_valid), 32'd1);
        check_eq("frame_width", 32'(frame_width), 32'(m_pw));
        check_eq("frame_height", 32'(frame_height), 32'(m_ph));
        check_eq("res_change", 32'(res_change), 32'(m_rc));
        check_eq("state_fe", 32'(state), enable ? 32'd2 : 32'd0);
        check_eq("line_y_fe", 32'(line_y), 32'd0);
        check_eq("sample_x_fe", 32'(sample_x), 32'd0);
        m_lines = 0;
        if (!d) begin
            vstep(1'b0, 1'b0);
            check_eq("stats_pulse", 32'(stats_valid), 32'd0);
        end
    endtask

    task automatic start_frame();
        vstep(1'b0, 1'b1);
        check_eq("state_frame", 32'(state), 32'd2);
        vstep(1'b0, 1'b0);
        m_lines = 0;
    endtask

    task automatic model_reset();
        m_prev_valid = 1'b0;
        m_pw = 0;
        m_ph = 0;
        m_rc = 1'b0;
        m_last_w = 0;
        m_lines = 0;
    endtask

    initial begin
        enable = 1'b0; vid_valid = 1'b1; vid_de = 1'b1; vid_v_sync = 1'b0;
        res_change_clr = 1'b0; gap_mode = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_count_cycle", 32'(count_cycle), 32'd0);
        check_eq("rst_sclr", 32'(sample_sclr), 32'd0);
        check_eq("rst_sample_x", 32'(sample_x), 32'd0);
        check_eq("rst_line_y", 32'(line_y), 32'd0);
        check_eq("rst_fw", 32'(frame_width), 32'd0);
        check_eq("rst_fh", 32'(frame_height), 32'd0);
        check_eq("rst_stats", 32'(stats_valid), 32'd0);
        check_eq("rst_rc", 32'(res_change), 32'd0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        check_eq("idle_hold", 32'(state), 32'd0);
        enable = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        check_eq("sync_wait", 32'(state), 32'd1);
        start_frame();

        // 4 x 18 then 4 x 15, change detection and clearing
        for (int l = 0; l < 4; l++) send_line(18, 3);
        frame_end(1'b0, 1'b0);
        for (int l = 0; l < 4; l++) send_line(15, 3);
        frame_end(1'b0, 1'b0);
        pulse_clr();
        for (int l = 0; l < 4; l++) send_line(18, 3);
        frame_end(1'b1, 1'b0);
        pulse_clr();

        // partial trailing sample
        for (int l = 0; l < 4; l++) send_line(17, 2);
        frame_end(1'b0, 1'b0);
        pulse_clr();

        // sync arriving mid-line aborts the line
        send_line(18, 3);
        for (int i = 0; i < 6; i++) vstep(1'b1, 1'b0);
        frame_end(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            vstep(1'b1, (i == 0));
            check_eq("abort_cc", 32'(cc_s), 32'd0);
            check_eq("abort_sx", 32'(sample_x), 32'd0);
        end
        vstep(1'b0, 1'b0);
        check_eq("abort_line_y", 32'(line_y), 32'd0);
        send_line(18, 3);
        frame_end(1'b0, 1'b0);
        pulse_clr();

        // vid_valid toggling every cycle
        gap_mode = 2;
        for (int l = 0; l < 4; l++) send_line(18, 3);
        frame_end(1'b0, 1'b0);

        // randomized frames with random valid gaps
        gap_mode = 1;
        for (int f = 0; f < 6; f++) begin
            int nl;
            nl = $urandom_range(1, 5);
            for (int l = 0; l < nl; l++) send_line($urandom_range(3, 30), $urandom_range(1, 4));
            frame_end(bit'($urandom_range(0, 3) == 0), 1'b0);
        end
        gap_mode = 0;
        pulse_clr();

        // enable dropped mid-frame
        send_line(18, 2);
        for (int i = 0; i < 9; i++) begin
            if (i == 3) enable = 1'b0;
            vstep(1'b1, 1'b0);
            check_eq("en_drop_state", 32'(state), 32'd2);
        end
        vstep(1'b0, 1'b0);
        m_lines++;
        m_last_w = 9 / NP;
        frame_end(1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_eq("idle_after_drop", 32'(state), 32'd0);
        pulse_clr();
        enable = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        check_eq("reenable", 32'(state), 32'd1);
        start_frame();
        for (int l = 0; l < 3; l++) send_line(12, 2);
        frame_end(1'b0, 1'b0);

        // asynchronous reset mid-line
        send_line(18, 2);
        for (int i = 0; i < 4; i++) vstep(1'b1, 1'b0);
        vid_valid = 1'b1; vid_de = 1'b1; vid_v_sync = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_state", 32'(state), 32'd0);
        check_eq("arst_cc", 32'(count_cycle), 32'd0);
        check_eq("arst_sx", 32'(sample_x), 32'd0);
        check_eq("arst_ly", 32'(line_y), 32'd0);
        check_eq("arst_fw", 32'(frame_width), 32'd0);
        check_eq("arst_fh", 32'(frame_height), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 1'b0);
        check_eq("post_rst_state", 32'(state), 32'd1);
        start_frame();
        for (int l = 0; l < 2; l++) send_line(21, 2);
        frame_end(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vip_cti_frame_sequencer.md
# vip_cti_frame_sequencer

Frame/line sequencer for the clocked-video-input datapath. It gates the per-cycle video stream into the colour-plane sample counter, issues that counter's synchronous clear at each line start, and tracks sample position within a line and line position within a frame. At each frame boundary it latches the measured active width and height and flags resolution changes to the control-register block.

## Interface
- NUMBER_OF_COLOUR_PLANES, 3: colour planes per sample.
- COLOUR_PLANES_ARE_IN_PARALLEL, 0: 1 = all planes arrive in one cycle.
- LOG2_NUMBER_OF_COLOUR_PLANES, 2: width of plane index.
- COUNTER_WIDTH, 16: width of all position and size counters.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  software run request
- vid_valid  in  1  qualifies every other vid_* input
- vid_de  in  1  active-video data enable
- vid_v_sync  in  1  vertical sync, active high
- count_sample  in  1  from sample counter: last plane of a sample accepted this cycle
- count_cycle  out  1  to sample counter: active plane accepted this cycle
- sample_sclr  out  1  to sample counter: synchronous clear at line start
- sample_x  out  COUNTER_WIDTH  completed samples in current line
- line_y  out  COUNTER_WIDTH  completed lines in current frame
- frame_width  out  COUNTER_WIDTH  latched active width
- frame_height  out  COUNTER_WIDTH  latched active height
- stats_valid  out  1  one-cycle pulse when frame_width/height update
- res_change  out  1  sticky resolution-change flag
- res_change_clr  in  1  clears res_change
- state  out  2  current FSM state

## Operation
- Edge detect: de_prev and vs_prev update only on vid_valid cycles. de_rise = vid_valid & vid_de & ~de_prev. de_fall = vid_valid & ~vid_de & de_prev. vs_rise = vid_valid & vid_v_sync & ~vs_prev.
- FSM states: IDLE=0, SYNC_WAIT=1, FRAME=2.
  - IDLE -> SYNC_WAIT when enable=1.
  - SYNC_WAIT -> FRAME on vs_rise. Clear sample_x, line_y and abort.
  - SYNC_WAIT -> IDLE when enable=0.
  - FRAME, on vs_rise (frame end): latch stats. Stay in FRAME if enable=1, else go to IDLE. enable is ignored at every other time in FRAME.
- count_cycle = vid_valid & vid_de & (state==FRAME) & ~abort. It is combinational.
- sample_sclr = count_cycle & ~de_prev. It coincides with the first plane of the line, so the counter loads that plane.
- sample_x:
  - On sample_sclr: load count_sample?1:0.
  - Otherwise, increment on count_sample.
  - Saturates at 2^COUNTER_WIDTH-1.
- On de_fall in FRAME with abort=0:
  - last_width <= sample_x.
  - line_y increments, saturating.
  - A trailing partial sample (planes incomplete) is discarded and is not counted.
- On de_fall with abort=1: clear abort. Do not update line_y or last_width.
- Frame end (vs_rise in FRAME):
  - frame_width <= last_width, frame_height <= line_y. stats_valid pulses.
  - Clear line_y and sample_x.
  - res_change sets if a previous latch exists since leaving IDLE and either value differs from the previous latch.
  - The first latch after IDLE never sets res_change.
- vs_rise while vid_de=1 (line in progress): the line is aborted. Set abort and clear sample_x. count_cycle stays low until the next de_rise after de_fall.
- vs_rise and de_rise in the same cycle: process the frame end first. The new line is line 0 of the new frame, and count_cycle/sample_sclr assert normally.
- res_change: a set and a res_change_clr in the same cycle leave res_change set.
- Entering IDLE clears the previous-latch-valid flag. frame_width and frame_height hold their values.

## Timing
- Reset values: all registers 0, state=IDLE. As a result, every output is 0.
- count_cycle and sample_sclr are combinational from the vid_* inputs, with zero latency.
- sample_x, line_y, frame_width, frame_height, stats_valid and res_change are registered. Each updates one clock after its triggering edge cycle.
- Cycles with vid_valid=0 change no state except res_change_clr.
- Assertion of rst mid-frame takes effect immediately and asynchronously. Release is synchronous to clk. After release, operation resumes from IDLE.

## Test plan
- 3 planes, sequential. enable=1, vs pulse, then 4 lines of 18 DE cycles, then vs -> frame_width=6, frame_height=4, stats_valid pulses once, res_change=0.
- Continue with a frame of 4 lines × 15 DE cycles -> frame_width=5, res_change=1. Then pulse res_change_clr -> res_change=0. Assert res_change_clr in the same cycle as a mismatching latch -> res_change stays 1.
- Line of 17 DE cycles (partial last sample) -> sample_x peaks at 5, last_width=5. sample_sclr is high exactly on the first DE cycle of each line.
- vs rises at DE cycle 7 of line 2 -> frame_height=1. count_cycle stays 0 for the rest of that DE run. The next full line gives line_y=1.
- vid_valid toggled 0/1 every cycle throughout the first scenario -> identical results (6 and 4).
- enable dropped mid-frame -> state stays FRAME until vs, then IDLE. Re-enable -> the first latch gives res_change=0 even though the size differs. rst asserted mid-line -> all outputs 0 immediately.
